// File: rtl/seq_pattern_ctrl_pkg.sv
// Shared definitions for the serial-pattern sequencer: controller state codes
// and the pattern loaded at reset.
package seq_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] DEF_PATTERN = 4'b1110;

endpackage

// File: rtl/seq_step_counter.sv
// Step index and pass counter for the pattern sequencer. A pass count of zero
// means continuous playback, so last_pass never asserts in that mode.
module seq_step_counter #(
  parameter int STEPS = 4,
  parameter int CW    = 4,
  parameter int IW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          clear,
  input  logic          init,
  input  logic          adv,
  input  logic [CW-1:0] reps,
  output logic [IW-1:0] step_idx,
  output logic          wrap,
  output logic          last_pass
);

  logic [CW-1:0] pass;

  assign wrap      = (step_idx == IW'(STEPS - 1));
  assign last_pass = (pass == CW'(1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_idx <= '0;
      pass     <= '0;
    end else if (clear) begin
      step_idx <= '0;
      pass     <= '0;
    end else if (init) begin
      step_idx <= '0;
      pass     <= reps;
    end else if (adv) begin
      if (wrap) begin
        step_idx <= '0;
        // Continuous mode (pass==0) never decrements.
        if (pass > CW'(1)) pass <= pass - 1'b1;
      end else begin
        step_idx <= step_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Programmable serial-pattern sequencer: plays a STEPS-bit pattern one bit per
// clock for a requested number of passes, with start/abort/busy/done handshake.
module seq_pattern_ctrl
  import seq_pattern_ctrl_pkg::*;
#(
  parameter int               STEPS   = 4,
  parameter int               CW      = 4,
  parameter logic [STEPS-1:0] RST_PAT = STEPS'(DEF_PATTERN),
  parameter int               IW      = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [STEPS-1:0] pattern_in,
  input  logic             start,
  input  logic [CW-1:0]    reps,
  input  logic             abort,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    step_idx
);

  state_t           state, state_nx;
  logic [STEPS-1:0] pattern, pattern_nx;
  logic             x_nx;
  logic             cnt_clear, cnt_init, cnt_adv;
  logic             wrap, last_pass;
  logic [IW-1:0]    idx_nx;
  logic             first_bit;

  seq_step_counter #(
    .STEPS (STEPS),
    .CW    (CW),
    .IW    (IW)
  ) u_counter (
    .clk       (clk),
    .clr       (clr),
    .clear     (cnt_clear),
    .init      (cnt_init),
    .adv       (cnt_adv),
    .reps      (reps),
    .step_idx  (step_idx),
    .wrap      (wrap),
    .last_pass (last_pass)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      pattern <= RST_PAT;
      x       <= 1'b0;
    end else begin
      state   <= state_nx;
      pattern <= pattern_nx;
      x       <= x_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pattern_nx = pattern;
    x_nx       = 1'b0;
    cnt_clear  = 1'b0;
    cnt_init   = 1'b0;
    cnt_adv    = 1'b0;
    idx_nx     = wrap ? '0 : step_idx + 1'b1;
    // A load in the same cycle as start takes effect for the first bit.
    first_bit  = load ? pattern_in[0] : pattern[0];
    case (state)
      ST_IDLE: begin
        if (load) pattern_nx = pattern_in;
        if (start) begin
          state_nx = ST_RUN;
          cnt_init = 1'b1;
          x_nx     = first_bit;
        end
      end
      ST_RUN: begin
        // Abort takes priority over the final wrap.
        if (abort || (wrap && last_pass)) begin
          state_nx  = ST_DONE;
          cnt_clear = 1'b1;
        end else begin
          cnt_adv = 1'b1;
          x_nx    = pattern[idx_nx];
        end
      end
      ST_DONE: begin
        if (load) pattern_nx = pattern_in;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx  = ST_IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Directed and randomized bench for seq_pattern_ctrl against a pass/step
// playback model of the expected output stream.
module tb_seq_pattern_ctrl;

  localparam int STEPS = 4;
  localparam int CW    = 4;

  logic             clk;
  logic             clr;
  logic             load;
  logic [STEPS-1:0] pattern_in;
  logic             start;
  logic [CW-1:0]    reps_in;
  logic             abort;
  logic             x;
  logic             busy;
  logic             done;
  logic [1:0]       step_idx;

  int total = 0;
  int bad   = 0;
  logic [3:0] mpat;

  seq_pattern_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .pattern_in (pattern_in),
    .start      (start),
    .reps       (reps_in),
    .abort      (abort),
    .x          (x),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ex, input logic eb,
                         input logic ed, input logic [1:0] ei);
    chk({tag, ".x"},    32'(x),        32'(ex));
    chk({tag, ".busy"}, 32'(busy),     32'(eb));
    chk({tag, ".done"}, 32'(done),     32'(ed));
    chk({tag, ".step"}, 32'(step_idx), 32'(ei));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dmode: 0 quiet, 1 load 4'b1111 and start every cycle, 2 random load/start
  task automatic run_seq(input string tag, input logic [3:0] mp, input int r, input int dmode);
    int n;
    n = r * STEPS;
    reps_in = CW'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    load  = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk_out(tag, mp[c % STEPS], 1'b1, 1'b0, 2'(c % STEPS));
      if (dmode == 1) begin
        load = 1'b1; pattern_in = 4'b1111; start = 1'b1;
      end else if (dmode == 2) begin
        load = 1'($urandom_range(0, 1)); pattern_in = 4'($urandom); start = 1'($urandom_range(0, 1));
      end
      tick();
    end
    chk_out({tag, ".donecyc"}, 1'b0, 1'b0, 1'b1, 2'd0);
    load  = 1'b0;
    start = (dmode != 0);
    tick();
    chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 2'd0);
    start = 1'b0;
    tick();
    chk_out({tag, ".idle2"}, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic run_abort(input string tag, input logic [3:0] mp, input int r, input int n);
    reps_in = CW'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    load  = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk_out(tag, mp[c % STEPS], 1'b1, 1'b0, 2'(c % STEPS));
      if (c == n - 1) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk_out({tag, ".abortcyc"}, 1'b0, 1'b0, 1'b1, 2'd0);
    tick();
    chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    clr = 1'b0; load = 1'b0; pattern_in = '0; start = 1'b0; reps_in = '0; abort = 1'b0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    #1 clr = 1'b1;
    tick();
    chk_out("post_reset", 1'b0, 1'b0, 1'b0, 2'd0);

    mpat = 4'b1110;
    run_seq("default_r1", mpat, 1, 0);

    load = 1'b1; pattern_in = 4'b0101;
    tick();
    load = 1'b0;
    mpat = 4'b0101;
    run_seq("p0101_r2", mpat, 2, 0);

    run_abort("cont_abort", mpat, 0, 10);

    load = 1'b1; pattern_in = 4'b0011;
    mpat = 4'b0011;
    run_seq("ldstart_0011", mpat, 1, 1);
    run_seq("after_midload", mpat, 2, 1);

    reps_in = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("rst_s0", mpat[0], 1'b1, 1'b0, 2'd0);
    tick();
    tick();
    chk_out("rst_s2", mpat[2], 1'b1, 1'b0, 2'd2);
    #3 clr = 1'b0;
    #1 chk_out("async_clr", 1'b0, 1'b0, 1'b0, 2'd0);
    #1 clr = 1'b1;
    tick();
    chk_out("after_clr", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_out("after_clr2", 1'b0, 1'b0, 1'b0, 2'd0);
    mpat = 4'b1110;
    run_seq("rst_pattern", mpat, 1, 0);

    for (int i = 0; i < 12; i++) begin
      int r;
      if ($urandom_range(0, 1) == 1) begin
        load = 1'b1;
        pattern_in = 4'($urandom);
        mpat = pattern_in;
      end
      r = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0)
        run_abort("rnd_abort", mpat, r, $urandom_range(1, r * STEPS));
      else
        run_seq("rnd_seq", mpat, r, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_ctrl.md
Name: seq_pattern_ctrl

Overview:
Programmable serial-pattern sequencer controller. It plays a STEPS-bit pattern out on a single-bit line, one bit per clock, for a requested number of passes, with start/abort/busy/done handshake. It replaces the fixed free-running pattern FSM with a controllable, reloadable sequencer. The output drives downstream strobe/enable logic.

Parameters:
STEPS, 4, pattern length in clock cycles (>=2)
CW, 4, width of repetition count
RST_PAT, 4'b1110, pattern value after reset; bit 0 plays first

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
load  input  1  capture pattern_in into pattern register (honoured only when not busy)
pattern_in  input  STEPS  new pattern; bit i is played at step i
start  input  1  begin sequence (honoured only in IDLE)
reps  input  CW  number of passes, sampled on accepted start; 0 = continuous
abort  input  1  terminate sequence at next edge
x  output  1  registered pattern bit
busy  output  1  high in RUN
done  output  1  one-cycle pulse after final step or abort
step_idx  output  $clog2(STEPS)  current step index

Behaviour:
- One clock domain: clk. Reset: clr asynchronous, active-low.
- Reset values: state=IDLE, pattern=RST_PAT, x=0, busy=0, done=0, step_idx=0, pass counter=0.
- States: IDLE, RUN, DONE. Encoding 2 bits: IDLE=0, RUN=1, DONE=2; code 3 is illegal and recovers to IDLE, x=0.
- IDLE: x=0, busy=0. On load: pattern<=pattern_in. On start: state<=RUN, step_idx<=0, pass counter<=reps, x<=bit 0 of the effective pattern.
- Load and start in the same IDLE cycle: the sequence uses pattern_in (load is applied first).
- Latency: x shows step 0 in the first cycle after start is sampled; busy rises in the same cycle.
- RUN: each edge step_idx<=step_idx+1 and x<=pattern[step_idx+1]. Wrap: at step_idx=STEPS-1, step_idx<=0.
  - If reps=0: continuous playback until abort.
  - Otherwise the pass counter decrements at each wrap. The wrap that ends the final pass goes to DONE instead of step 0.
- DONE: lasts one cycle; done=1, x=0, busy=0; then IDLE. A start in DONE is ignored.
- abort in RUN: state<=DONE at the next edge, x<=0. It wins over a simultaneous wrap or final step. abort in IDLE or DONE has no effect.
- load or start while busy: ignored. The pattern register is unchanged and no error flag is raised.
- Reset mid-sequence: immediate return to the reset values. No done pulse.
- Total RUN cycles for reps=R>0: R*STEPS. The done pulse follows in the next cycle.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_RUN, ST_DONE) and the default pattern constant.
- Natural sub-module: seq_step_counter. It holds the step index plus pass counter, provides wrap and last-pass flags, and has the same clk/clr reset.
- The FSM and output register stay in the top module.

Test Plan:
- Reset, then start with reps=1 and the default pattern -> x = 0,1,1,1 over 4 cycles, busy high for 4 cycles, done pulses on cycle 5, then IDLE.
- load pattern_in=4'b0101 in IDLE, start with reps=2 -> x = 1,0,1,0,1,0,1,0, then a single done pulse.
- Start with reps=0 and hold for 10 cycles, then abort -> x repeats the pattern continuously; x=0 and done=1 in the cycle after abort, busy drops.
- Pulse load=4'b0011 and start together -> x = 1,1,0,0; an extra load of 4'b1111 pulsed mid-run does not change the current or next run.
- Drive clr low at step 2 of a run -> x, busy, done and step_idx go to 0 asynchronously, the pattern returns to 4'b1110, and no done pulse occurs.
- Assert start during RUN and during DONE -> no restart and no second done pulse; the sequence length stays exactly reps*STEPS.
